// File: rtl/data_mem_responder.sv
// Word-addressed data memory serving processor loads/stores, with a camera
// fill mode that packs incoming bytes little-endian into consecutive words.
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] WriteAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        load_start,
    input  logic        cam_valid,
    input  logic [7:0]  cam_data,
    output logic        cam_ready,
    output logic        busy,
    output logic        load_done,
    output logic        err_oor
);

    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_read_data;
    logic        r_load_done;
    logic        r_err_oor;
    logic [1:0]  r_byte_cnt;
    logic [AW-1:0] r_word_ptr;
    logic [23:0] r_pack;

    logic [AW-1:0] w_index;
    logic        w_in_range;
    logic        w_serve;
    logic        w_store;
    logic        w_byte_fire;
    logic        w_word_fire;
    logic        w_last_word;
    logic        w_load_write;
    logic [31:0] w_word;

    assign w_index      = WriteAddress[AW+1:2];
    assign w_in_range   = (WriteAddress[31:AW+2] == '0);
    assign w_serve      = (r_state == SERVE);
    // Every memory write is gated by reset so reset wins even though the array itself is never cleared.
    assign w_store      = reset & w_serve & write_enable & w_in_range;
    assign w_byte_fire  = cam_valid & cam_ready;
    assign w_word_fire  = w_byte_fire & (r_byte_cnt == 2'd3);
    assign w_last_word  = w_word_fire & (r_word_ptr == AW'(DEPTH - 1));
    assign w_load_write = reset & w_word_fire;
    assign w_word       = {cam_data, r_pack};

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_next_state = r_state;
        cam_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            SERVE: begin
                if (load_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                cam_ready = 1'b1;
                busy      = 1'b1;
                if (w_last_word) begin
                    w_next_state = SERVE;
                end
            end
            default: w_next_state = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: non-blocking assignments here make a same-edge read of r_mem see the old word (read-first).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_read_data <= '0;
            r_err_oor   <= 1'b0;
            r_load_done <= 1'b0;
            r_byte_cnt  <= '0;
            r_word_ptr  <= '0;
        end else begin
            r_load_done <= w_last_word;
            r_err_oor   <= w_serve & ~w_in_range;

            if (w_serve && !load_start && w_in_range) begin
                r_read_data <= r_mem[w_index];
            end else begin
                r_read_data <= '0;
            end

            if (w_serve && load_start) begin
                r_byte_cnt <= '0;
                r_word_ptr <= '0;
            end else if (w_byte_fire) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (w_word_fire) begin
                    r_word_ptr <= r_word_ptr + AW'(1);
                end
            end
        end
    end

    // NOTE: the memory array and the pack register carry no reset; the byte counter alone decides which packed bytes count.
    always_ff @(posedge clk) begin
        if (w_byte_fire) begin
            case (r_byte_cnt)
                2'd0:    r_pack[7:0]   <= cam_data;
                2'd1:    r_pack[15:8]  <= cam_data;
                2'd2:    r_pack[23:16] <= cam_data;
                default: r_pack        <= r_pack;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_index] <= WriteData;
        end else if (w_load_write) begin
            r_mem[r_word_ptr] <= w_word;
        end
    end

    assign ReadData  = r_read_data;
    assign load_done = r_load_done;
    assign err_oor   = r_err_oor;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit data words; power of two.
REQ-002 Parameter: AW, log2(DEPTH) = 8, word-index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 write_enable  input  1  processor store strobe.
REQ-006 WriteAddress  input  32  processor byte address for loads and stores.
REQ-007 WriteData  input  32  processor store data.
REQ-008 ReadData  output  32  load data returned to the processor, registered.
REQ-009 load_start  input  1  single-cycle request to begin a camera frame load.
REQ-010 cam_valid  input  1  camera byte valid.
REQ-011 cam_data  input  8  camera pixel byte.
REQ-012 cam_ready  output  1  responder accepts a camera byte this cycle.
REQ-013 busy  output  1  high while a frame load is in progress.
REQ-014 load_done  output  1  one-cycle pulse when a frame load completes.
REQ-015 err_oor  output  1  one-cycle pulse on an out-of-range processor access.

Function
REQ-016 The block SHALL implement a two-state FSM: SERVE (processor access) and LOAD (camera fill).
REQ-017 Word index SHALL be WriteAddress[AW+1:2]; WriteAddress[1:0] are ignored.
REQ-018 Out-of-range SHALL mean WriteAddress[31:AW+2] != 0; the store is dropped, the next-cycle ReadData is 0, and err_oor pulses in the following cycle.
REQ-019 In SERVE, ReadData SHALL equal mem[index] sampled at edge N and visible after edge N (1-cycle latency), for every cycle regardless of write_enable.
REQ-020 In SERVE with write_enable=1 and an in-range address, mem[index] SHALL take WriteData at the edge.
REQ-021 Same-cycle read and write to one index SHALL be read-first: ReadData shows the old word, and the new word is visible from the next access.
REQ-022 A load_start sampled in SERVE SHALL move the FSM to LOAD at that edge and clear the byte counter (2 bits) and word pointer (AW bits).
REQ-023 In LOAD: cam_ready=1 and busy=1; processor stores are ignored, ReadData is held at 0, and err_oor stays 0.
REQ-024 A byte SHALL transfer only when cam_valid & cam_ready; bytes pack little-endian (first byte to bits 7:0).
REQ-025 The word SHALL be written to mem[word pointer] on the edge that accepts its 4th byte; the pointer then increments and the byte counter wraps to 0.
REQ-026 After the 4th byte of word DEPTH-1 is accepted, the FSM SHALL return to SERVE, the pointer SHALL wrap to 0, and load_done SHALL pulse for exactly the next cycle; cam_ready drops in that same cycle.
REQ-027 cam_valid=0 in LOAD SHALL stall the fill with no state change and no timeout.
REQ-028 load_start while in LOAD SHALL be ignored; the load is not restarted.
REQ-029 cam_valid in SERVE SHALL be ignored (cam_ready=0).
REQ-030 A load_start coincident with write_enable in SERVE SHALL let the store complete at that edge, then enter LOAD.

Reset
REQ-031 With reset=0 at an edge, the block SHALL set: FSM=SERVE, ReadData=0, cam_ready=0, busy=0, load_done=0, err_oor=0, byte counter=0, pointer=0.
REQ-032 Memory contents SHALL NOT be cleared by reset; words already written in an aborted LOAD are retained, and a partial packed word is discarded.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Store 0xDEADBEEF to addr 0x10, then load 0x10 -> ReadData=0xDEADBEEF one cycle after the load address is applied.
REQ-035 Store 0x1 and load 0x20 in the same cycle, over old value 0x5 -> ReadData=0x5; a load next cycle -> 0x1.
REQ-036 Access at addr 0x400 with write_enable=1 -> err_oor pulse, ReadData=0, and mem[0] unchanged.
REQ-037 load_start, then 1024 bytes 0x00..0xFF repeating, with cam_valid toggling every other cycle -> busy high throughout, mem[0]=0x03020100, mem[255]=0xFFFEFDFC, one load_done pulse, then back in SERVE.
REQ-038 reset=0 after 6 bytes of a load -> SERVE, all outputs at reset values, mem[0] holds the packed first word, and the partial word is lost.
REQ-039 load_start during LOAD plus a processor store during LOAD -> no restart, store dropped, and ReadData=0 until load_done.
